// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: write-back control encodings,
// load/store size codes carried in funct3, the FSM state type and small
// decode helpers used by both the top level and the load-extract block.
package writeback_unit_pkg;

    // What the executed instruction wants done with its result.
    typedef enum logic [2:0] {
        WB_NONE  = 3'd0,
        WB_ALU   = 3'd1,
        WB_LOAD  = 3'd2,
        WB_STORE = 3'd3,
        WB_LINK  = 3'd4
    } wb_ctrl_e;

    // funct3 access-size codes.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WB
    } wb_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } acc_size_e;

    // Codes 5-7 are reserved and behave exactly like "no write-back".
    function automatic wb_ctrl_e decode_ctrl(input logic [2:0] code);
        case (code)
            3'd1:    return WB_ALU;
            3'd2:    return WB_LOAD;
            3'd3:    return WB_STORE;
            3'd4:    return WB_LINK;
            default: return WB_NONE;
        endcase
    endfunction

    // Unlisted funct3 values fall back to a full-word access.
    function automatic acc_size_e size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/writeback_unit_load_extract.sv
// Load data extraction: picks the addressed byte/halfword out of the
// returned memory word and sign- or zero-extends it to the register width.
// Ports:
//   funct3  in   3     access size / signedness
//   lane    in   2     byte offset within the word (addr[1:0])
//   word    in   XLEN  raw word from memory
//   data    out  XLEN  value to write to the register file
module writeback_unit_load_extract
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword accesses are aligned by the time a load is issued, so only
        // lane[1] selects the half.
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_s   = byte_sel;
        half_s   = half_sel;

        case (funct3)
            F3_B:    data = XLEN'(byte_s);
            F3_H:    data = XLEN'(half_s);
            F3_BU:   data = XLEN'(byte_sel);
            F3_HU:   data = XLEN'(half_sel);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: accepts one executed instruction at a time, performs the
// load/store memory access through a request/response handshake when
// needed, then drives the register-file write port.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   io_in_valid/ready       instruction handshake from execute (ready only in IDLE)
//   io_wb_control           0 none, 1 ALU, 2 load, 3 store, 4 link; 5-7 = none
//   io_funct3               access size (b, h, w, bu, hu; others = w)
//   io_alu_result           result or effective address
//   io_store_data           store source value
//   io_pc_count             instruction PC (link writes pc+4)
//   io_rd                   destination register
//   io_mem_req_*            memory request: valid/ready, wen, addr, wdata, wmask
//   io_mem_resp_valid/data  read data or store acknowledge
//   io_rf_wen/waddr/wdata   register-file write port
//   io_misaligned           one-cycle pulse when an access is dropped
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RF_ADDR = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [2:0]         io_wb_control,
    input  logic [2:0]         io_funct3,
    input  logic [XLEN-1:0]    io_alu_result,
    input  logic [XLEN-1:0]    io_store_data,
    input  logic [XLEN-1:0]    io_pc_count,
    input  logic [RF_ADDR-1:0] io_rd,
    output logic               io_mem_req_valid,
    input  logic               io_mem_req_ready,
    output logic               io_mem_req_wen,
    output logic [XLEN-1:0]    io_mem_addr,
    output logic [XLEN-1:0]    io_mem_wdata,
    output logic [3:0]         io_mem_wmask,
    input  logic               io_mem_resp_valid,
    input  logic [XLEN-1:0]    io_mem_resp_data,
    output logic               io_rf_wen,
    output logic [RF_ADDR-1:0] io_rf_waddr,
    output logic [XLEN-1:0]    io_rf_wdata,
    output logic               io_misaligned
);

    wb_state_e          state;
    wb_state_e          state_next;
    wb_ctrl_e           in_ctrl;
    wb_ctrl_e           ctrl_q;
    acc_size_e          in_size;
    acc_size_e          size_q;
    logic [2:0]         funct3_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    store_data_q;
    logic [RF_ADDR-1:0] rd_q;
    logic [RF_ADDR-1:0] rf_waddr_q;
    logic [XLEN-1:0]    rf_wdata_q;
    logic [XLEN-1:0]    load_data;
    logic               misaligned_q;
    logic               accept;
    logic               in_mem_op;
    logic               in_misaligned;

    assign in_ctrl   = decode_ctrl(io_wb_control);
    assign in_size   = size_of(io_funct3);
    assign size_q    = size_of(funct3_q);
    assign accept    = io_in_valid && (state == ST_IDLE);
    assign in_mem_op = (in_ctrl == WB_LOAD) || (in_ctrl == WB_STORE);

    always_comb begin
        in_misaligned = 1'b0;
        case (in_size)
            SZ_H:    in_misaligned = io_alu_result[0];
            SZ_W:    in_misaligned = |io_alu_result[1:0];
            default: in_misaligned = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (in_ctrl)
                        WB_ALU, WB_LINK:   state_next = ST_WB;
                        WB_LOAD, WB_STORE: state_next = in_misaligned ? ST_IDLE : ST_REQ;
                        default:           state_next = ST_IDLE;
                    endcase
                end
            end
            ST_REQ: begin
                if (io_mem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response coincident with the request handshake arrives
                // while still in REQ and is therefore never seen here.
                if (io_mem_resp_valid) begin
                    state_next = (ctrl_q == WB_LOAD) ? ST_WB : ST_IDLE;
                end
            end
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Instruction latch and register-file write data
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q       <= WB_NONE;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= accept && in_mem_op && in_misaligned;
            if (accept) begin
                ctrl_q       <= in_ctrl;
                funct3_q     <= io_funct3;
                addr_q       <= io_alu_result;
                store_data_q <= io_store_data;
                rd_q         <= io_rd;
                // Write data is only updated on the way into WB so the port
                // holds its last value at all other times.
                if (in_ctrl == WB_ALU) begin
                    rf_waddr_q <= io_rd;
                    rf_wdata_q <= io_alu_result;
                end else if (in_ctrl == WB_LINK) begin
                    rf_waddr_q <= io_rd;
                    rf_wdata_q <= io_pc_count + XLEN'(4);
                end
            end
            if ((state == ST_WAIT) && io_mem_resp_valid && (ctrl_q == WB_LOAD)) begin
                rf_waddr_q <= rd_q;
                rf_wdata_q <= load_data;
            end
        end
    end

    writeback_unit_load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .funct3 (funct3_q),
        .lane   (addr_q[1:0]),
        .word   (io_mem_resp_data),
        .data   (load_data)
    );

    // Store lanes: sub-word data is replicated across the word and the
    // byte enables pick the addressed lane(s). Loads drive zero mask/data.
    always_comb begin
        io_mem_wmask = 4'b0000;
        io_mem_wdata = '0;
        if (ctrl_q == WB_STORE) begin
            case (size_q)
                SZ_B: begin
                    io_mem_wmask = 4'b0001 << addr_q[1:0];
                    io_mem_wdata = {4{store_data_q[7:0]}};
                end
                SZ_H: begin
                    io_mem_wmask = 4'b0011 << {addr_q[1], 1'b0};
                    io_mem_wdata = {2{store_data_q[15:0]}};
                end
                default: begin
                    io_mem_wmask = 4'b1111;
                    io_mem_wdata = store_data_q;
                end
            endcase
        end
    end

    assign io_in_ready      = (state == ST_IDLE);
    assign io_mem_req_valid = (state == ST_REQ);
    assign io_mem_req_wen   = (ctrl_q == WB_STORE);
    assign io_mem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign io_rf_wen        = (state == ST_WB) && (rf_waddr_q != '0);
    assign io_rf_waddr      = rf_waddr_q;
    assign io_rf_wdata      = rf_wdata_q;
    assign io_misaligned    = misaligned_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand-written multi-cycle
// corner sequences, and randomized instructions checked against a
// behavioural reference model.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [2:0]  io_wb_control;
    logic [2:0]  io_funct3;
    logic [31:0] io_alu_result;
    logic [31:0] io_store_data;
    logic [31:0] io_pc_count;
    logic [4:0]  io_rd;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic        io_mem_req_wen;
    logic [31:0] io_mem_addr;
    logic [31:0] io_mem_wdata;
    logic [3:0]  io_mem_wmask;
    logic        io_mem_resp_valid;
    logic [31:0] io_mem_resp_data;
    logic        io_rf_wen;
    logic [4:0]  io_rf_waddr;
    logic [31:0] io_rf_wdata;
    logic        io_misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    writeback_unit dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_wb_control     (io_wb_control),
        .io_funct3         (io_funct3),
        .io_alu_result     (io_alu_result),
        .io_store_data     (io_store_data),
        .io_pc_count       (io_pc_count),
        .io_rd             (io_rd),
        .io_mem_req_valid  (io_mem_req_valid),
        .io_mem_req_ready  (io_mem_req_ready),
        .io_mem_req_wen    (io_mem_req_wen),
        .io_mem_addr       (io_mem_addr),
        .io_mem_wdata      (io_mem_wdata),
        .io_mem_wmask      (io_mem_wmask),
        .io_mem_resp_valid (io_mem_resp_valid),
        .io_mem_resp_data  (io_mem_resp_data),
        .io_rf_wen         (io_rf_wen),
        .io_rf_waddr       (io_rf_waddr),
        .io_rf_wdata       (io_rf_wdata),
        .io_misaligned     (io_misaligned)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          stalls;
        int          delay;
        logic [31:0] resp;
    } vin_t;

    typedef struct {
        int          rf_cnt;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          rf_cycle;
        int          mis_cnt;
        int          hs_cnt;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] mwdata;
        int          end_cycle;
        int          unstable;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t e;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vin_t v);
        io_wb_control = v.ctrl;
        io_funct3     = v.f3;
        io_alu_result = v.alu;
        io_store_data = v.sd;
        io_pc_count   = v.pc;
        io_rd         = v.rd;
    endtask

    // Drives one instruction and acts as the memory, recording what the DUT
    // did. Cycle k=1 is the first cycle after the accepting edge.
    task automatic run_instr(input vin_t v, output vout_t o);
        int          stall_left;
        int          resp_in;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wmask;
        o = '{default: 0};
        set_inputs(v);
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        stall_left = v.stalls;
        resp_in = -1;
        s_addr = '0; s_wdata = '0; s_wmask = '0;
        for (int k = 1; k <= 60; k++) begin
            io_mem_req_ready  = 1'b0;
            io_mem_resp_valid = 1'b0;
            if (io_misaligned) o.mis_cnt++;
            if (io_rf_wen) begin
                o.rf_cnt++;
                o.waddr = io_rf_waddr;
                o.wdata = io_rf_wdata;
                o.rf_cycle = k;
            end
            if (io_in_ready) begin
                o.end_cycle = k;
                break;
            end
            if (resp_in > 0) begin
                resp_in--;
                if (resp_in == 0) begin
                    io_mem_resp_valid = 1'b1;
                    io_mem_resp_data  = v.resp;
                    resp_in = -1;
                end
            end
            if (io_mem_req_valid) begin
                if (stall_left != v.stalls) begin
                    if (io_mem_addr !== s_addr || io_mem_wdata !== s_wdata || io_mem_wmask !== s_wmask)
                        o.unstable++;
                end
                s_addr = io_mem_addr; s_wdata = io_mem_wdata; s_wmask = io_mem_wmask;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    io_mem_req_ready = 1'b1;
                    o.hs_cnt++;
                    o.addr   = io_mem_addr;
                    o.wen    = io_mem_req_wen;
                    o.wmask  = io_mem_wmask;
                    o.mwdata = io_mem_wdata;
                    resp_in  = v.delay + 1;
                end
            end
            @(posedge clock); #1;
        end
        io_mem_req_ready  = 1'b0;
        io_mem_resp_valid = 1'b0;
        // One trailing cycle to catch stretched pulses or stray writes.
        @(posedge clock); #1;
        if (io_misaligned) o.mis_cnt++;
        if (io_rf_wen) o.rf_cnt++;
    endtask

    task automatic compare(input string tag, input vout_t a, input vout_t e);
        chk({tag, ".done"}, 64'(a.end_cycle != 0), 64'(1));
        chk({tag, ".end_cycle"}, 64'(a.end_cycle), 64'(e.end_cycle));
        chk({tag, ".rf_cnt"}, 64'(a.rf_cnt), 64'(e.rf_cnt));
        if (e.rf_cnt != 0) begin
            chk({tag, ".rf_waddr"}, 64'(a.waddr), 64'(e.waddr));
            chk({tag, ".rf_wdata"}, 64'(a.wdata), 64'(e.wdata));
            chk({tag, ".rf_cycle"}, 64'(a.rf_cycle), 64'(e.rf_cycle));
        end
        chk({tag, ".misaligned"}, 64'(a.mis_cnt), 64'(e.mis_cnt));
        chk({tag, ".req_handshakes"}, 64'(a.hs_cnt), 64'(e.hs_cnt));
        if (e.hs_cnt != 0) begin
            chk({tag, ".mem_addr"}, 64'(a.addr), 64'(e.addr));
            chk({tag, ".mem_wen"}, 64'(a.wen), 64'(e.wen));
            chk({tag, ".mem_wmask"}, 64'(a.wmask), 64'(e.wmask));
            chk({tag, ".mem_wdata"}, 64'(a.mwdata), 64'(e.mwdata));
            chk({tag, ".req_stable"}, 64'(a.unstable), 64'(0));
        end
    endtask

    // Reference model: behaviour computed from sizes, offsets and arithmetic.
    function automatic vout_t model(input vin_t v);
        vout_t       e;
        int          c;
        int          sz;
        int          off;
        logic [63:0] val;
        logic [63:0] span;
        e = '{default: 0};
        c   = (v.ctrl <= 3'd4) ? int'(v.ctrl) : 0;
        sz  = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        off = int'(v.alu % 4);
        e.end_cycle = 1;
        if (c == 1 || c == 4) begin
            e.end_cycle = 2;
            e.waddr = v.rd;
            e.wdata = (c == 1) ? v.alu : 32'(v.pc + 32'd4);
            e.rf_cycle = 1;
            e.rf_cnt = (v.rd != 0) ? 1 : 0;
        end else if (c == 2 || c == 3) begin
            if ((v.alu % sz) != 0) begin
                e.mis_cnt = 1;
            end else begin
                e.hs_cnt = 1;
                e.addr = v.alu - 32'(off);
                e.wen = (c == 3);
                if (c == 3) begin
                    e.end_cycle = v.stalls + v.delay + 3;
                    e.wmask = 4'(((1 << sz) - 1) << off);
                    case (sz)
                        1:       e.mwdata = {24'd0, v.sd[7:0]} * 32'h01010101;
                        2:       e.mwdata = {16'd0, v.sd[15:0]} * 32'h00010001;
                        default: e.mwdata = v.sd;
                    endcase
                end else begin
                    e.end_cycle = v.stalls + v.delay + 4;
                    span = 64'd1 << (8 * sz);
                    val = (64'(v.resp) >> (8 * off)) % span;
                    if ((v.f3 == 3'd0 || v.f3 == 3'd1) && val >= span / 2)
                        val = val - span;
                    e.waddr = v.rd;
                    e.wdata = val[31:0];
                    e.rf_cycle = v.stalls + v.delay + 3;
                    e.rf_cnt = (v.rd != 0) ? 1 : 0;
                end
            end
        end
        return e;
    endfunction

    function automatic vin_t mk(input logic [2:0] ctrl, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd,
                                input int stalls, input int delay, input logic [31:0] resp);
        vin_t v;
        v.ctrl = ctrl; v.f3 = f3; v.alu = alu; v.sd = sd; v.pc = pc; v.rd = rd;
        v.stalls = stalls; v.delay = delay; v.resp = resp;
        return v;
    endfunction

    function automatic vout_t ex(input int rf_cnt, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input int rf_cycle, input int mis, input int hs, input logic [31:0] addr,
                                 input logic wen, input logic [3:0] wmask, input logic [31:0] mwdata,
                                 input int end_cycle);
        vout_t e;
        e = '{default: 0};
        e.rf_cnt = rf_cnt; e.waddr = waddr; e.wdata = wdata; e.rf_cycle = rf_cycle;
        e.mis_cnt = mis; e.hs_cnt = hs; e.addr = addr; e.wen = wen; e.wmask = wmask;
        e.mwdata = mwdata; e.end_cycle = end_cycle;
        return e;
    endfunction

    vec_t  vecs[15];
    vin_t  vi;
    vout_t vo;
    vout_t ve;

    initial begin
        reset = 1'b1;
        io_in_valid = 1'b0;
        io_wb_control = '0; io_funct3 = '0; io_alu_result = '0; io_store_data = '0;
        io_pc_count = '0; io_rd = '0; io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0;
        io_mem_resp_data = '0;

        //            ctrl  f3    alu           sd            pc            rd     st d  resp
        vecs[0].i  = mk(3'd1, 3'd2, 32'h1234,     32'h0,        32'h0,        5'd5,  0, 0, 32'h0);
        vecs[0].e  = ex(1, 5'd5, 32'h1234, 1, 0, 0, 32'h0, 0, 4'h0, 32'h0, 2);
        vecs[1].i  = mk(3'd2, 3'd0, 32'h103,      32'h0,        32'h0,        5'd7,  2, 0, 32'h80FFFFFF);
        vecs[1].e  = ex(1, 5'd7, 32'hFFFFFF80, 5, 0, 1, 32'h100, 0, 4'h0, 32'h0, 6);
        vecs[2].i  = mk(3'd3, 3'd1, 32'h202,      32'hAAAABEEF, 32'h0,        5'd9,  0, 1, 32'h0);
        vecs[2].e  = ex(0, 5'd0, 32'h0, 0, 0, 1, 32'h200, 1, 4'hC, 32'hBEEFBEEF, 4);
        vecs[3].i  = mk(3'd2, 3'd2, 32'h101,      32'h0,        32'h0,        5'd3,  0, 0, 32'h0);
        vecs[3].e  = ex(0, 5'd0, 32'h0, 0, 1, 0, 32'h0, 0, 4'h0, 32'h0, 1);
        vecs[4].i  = mk(3'd4, 3'd0, 32'h0,        32'h0,        32'hFFFFFFFC, 5'd0,  0, 0, 32'h0);
        vecs[4].e  = ex(0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 2);
        vecs[5].i  = mk(3'd4, 3'd0, 32'h0,        32'h0,        32'hFFFFFFFC, 5'd1,  0, 0, 32'h0);
        vecs[5].e  = ex(1, 5'd1, 32'h0, 1, 0, 0, 32'h0, 0, 4'h0, 32'h0, 2);
        vecs[6].i  = mk(3'd2, 3'd5, 32'h1002,     32'h0,        32'h0,        5'd10, 0, 0, 32'h80011234);
        vecs[6].e  = ex(1, 5'd10, 32'h00008001, 3, 0, 1, 32'h1000, 0, 4'h0, 32'h0, 4);
        vecs[7].i  = mk(3'd2, 3'd1, 32'h1002,     32'h0,        32'h0,        5'd11, 0, 0, 32'h80011234);
        vecs[7].e  = ex(1, 5'd11, 32'hFFFF8001, 3, 0, 1, 32'h1000, 0, 4'h0, 32'h0, 4);
        vecs[8].i  = mk(3'd6, 3'd2, 32'h55,       32'h0,        32'h0,        5'd4,  0, 0, 32'h0);
        vecs[8].e  = ex(0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);
        vecs[9].i  = mk(3'd3, 3'd0, 32'h201,      32'h1234565A, 32'h0,        5'd0,  1, 0, 32'h0);
        vecs[9].e  = ex(0, 5'd0, 32'h0, 0, 0, 1, 32'h200, 1, 4'h2, 32'h5A5A5A5A, 4);
        vecs[10].i = mk(3'd2, 3'd2, 32'h300,      32'h0,        32'h0,        5'd31, 0, 2, 32'hDEADBEEF);
        vecs[10].e = ex(1, 5'd31, 32'hDEADBEEF, 5, 0, 1, 32'h300, 0, 4'h0, 32'h0, 6);
        vecs[11].i = mk(3'd3, 3'd2, 32'h302,      32'h0,        32'h0,        5'd0,  0, 0, 32'h0);
        vecs[11].e = ex(0, 5'd0, 32'h0, 0, 1, 0, 32'h0, 0, 4'h0, 32'h0, 1);
        vecs[12].i = mk(3'd2, 3'd2, 32'h20,       32'h0,        32'h0,        5'd0,  0, 0, 32'h11);
        vecs[12].e = ex(0, 5'd0, 32'h0, 0, 0, 1, 32'h20, 0, 4'h0, 32'h0, 4);
        vecs[13].i = mk(3'd2, 3'd4, 32'h41,       32'h0,        32'h0,        5'd2,  0, 0, 32'h0000F700);
        vecs[13].e = ex(1, 5'd2, 32'h000000F7, 3, 0, 1, 32'h40, 0, 4'h0, 32'h0, 4);
        vecs[14].i = mk(3'd3, 3'd2, 32'h10,       32'h01234567, 32'h0,        5'd6,  0, 0, 32'h0);
        vecs[14].e = ex(0, 5'd0, 32'h0, 0, 0, 1, 32'h10, 1, 4'hF, 32'h01234567, 3);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        chk("reset.in_ready", 64'(io_in_ready), 64'(1));
        chk("reset.req_valid", 64'(io_mem_req_valid), 64'(0));
        chk("reset.rf_wen", 64'(io_rf_wen), 64'(0));
        chk("reset.misaligned", 64'(io_misaligned), 64'(0));
        chk("reset.rf_waddr", 64'(io_rf_waddr), 64'(0));
        chk("reset.rf_wdata", 64'(io_rf_wdata), 64'(0));

        // Directed vector table
        for (int n = 0; n < 15; n++) begin
            run_instr(vecs[n].i, vo);
            compare($sformatf("vec%0d", n), vo, vecs[n].e);
        end

        // Write port holds the last written value after non-writing instructions.
        chk("hold.rf_waddr", 64'(io_rf_waddr), 64'(5'd2));
        chk("hold.rf_wdata", 64'(io_rf_wdata), 64'(32'h000000F7));

        // Response coincident with the request handshake is ignored.
        set_inputs(mk(3'd2, 3'd2, 32'h500, 32'h0, 32'h0, 5'd6, 0, 0, 32'h0));
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        chk("samecyc.req_valid", 64'(io_mem_req_valid), 64'(1));
        io_mem_req_ready = 1'b1;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data = 32'h11111111;
        @(posedge clock); #1;
        io_mem_req_ready = 1'b0;
        io_mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("samecyc.still_waiting", 64'({io_in_ready, io_rf_wen, io_mem_req_valid}), 64'(0));
            @(posedge clock); #1;
        end
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data = 32'h22222222;
        @(posedge clock); #1;
        io_mem_resp_valid = 1'b0;
        chk("samecyc.rf_wen", 64'(io_rf_wen), 64'(1));
        chk("samecyc.rf_waddr", 64'(io_rf_waddr), 64'(5'd6));
        chk("samecyc.rf_wdata", 64'(io_rf_wdata), 64'(32'h22222222));
        @(posedge clock); #1;
        chk("samecyc.in_ready", 64'(io_in_ready), 64'(1));

        // Reset while a request is pending drops it the next cycle.
        set_inputs(mk(3'd3, 3'd2, 32'h700, 32'hCAFE, 32'h0, 5'd0, 0, 0, 32'h0));
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        chk("rstreq.req_valid_before", 64'(io_mem_req_valid), 64'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rstreq.req_valid_after", 64'(io_mem_req_valid), 64'(0));
        chk("rstreq.in_ready", 64'(io_in_ready), 64'(1));

        // Reset during WAIT, then a late response after release.
        set_inputs(mk(3'd2, 3'd2, 32'h600, 32'h0, 32'h0, 5'd8, 0, 0, 32'h0));
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        io_mem_req_ready = 1'b1;
        @(posedge clock); #1;
        io_mem_req_ready = 1'b0;
        chk("rstwait.waiting", 64'(io_in_ready), 64'(0));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rstwait.req_valid", 64'(io_mem_req_valid), 64'(0));
        chk("rstwait.in_ready", 64'(io_in_ready), 64'(1));
        chk("rstwait.rf_wdata", 64'(io_rf_wdata), 64'(0));
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data = 32'h33333333;
        @(posedge clock); #1;
        io_mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstwait.no_write", 64'({io_rf_wen, io_in_ready}), 64'(2'b01));
            @(posedge clock); #1;
        end

        // Randomized instructions against the reference model
        for (int n = 0; n < 200; n++) begin
            vi.ctrl   = 3'($urandom_range(0, 7));
            vi.f3     = 3'($urandom_range(0, 7));
            vi.alu    = $urandom;
            vi.sd     = $urandom;
            vi.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            vi.rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            vi.stalls = $urandom_range(0, 3);
            vi.delay  = $urandom_range(0, 2);
            vi.resp   = $urandom;
            run_instr(vi, vo);
            ve = model(vi);
            compare($sformatf("rand%0d", n), vo, ve);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
